// File: rtl/can_regs_pkg.sv
// PeliCAN (SJA1000 extended mode) register map, command/status bits and
// sequencer state encoding shared by the RX drain master and its bus engine.
package can_regs_pkg;

  // Register addresses on the controller's 8-bit register port
  localparam logic [7:0] ADR_CMD         = 8'd1;
  localparam logic [7:0] ADR_SR          = 8'd2;
  localparam logic [7:0] ADR_RX_FI       = 8'd16;
  localparam logic [7:0] ADR_RX_ID       = 8'd17;
  localparam logic [7:0] ADR_RX_DATA_EXT = 8'd21;
  localparam logic [7:0] ADR_RX_DATA_STD = 8'd19;

  // Release-receive-buffer command and receive-buffer-status bit position
  localparam logic [7:0] CMD_RRB = 8'h04;
  localparam int         SR_RBS  = 0;

  // Sequencer state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_POLL    = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_FI      = 3'd3;
  localparam logic [2:0] ST_ID      = 3'd4;
  localparam logic [2:0] ST_DATA    = 3'd5;
  localparam logic [2:0] ST_REL     = 3'd6;
  localparam logic [2:0] ST_PRESENT = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_POLL    = ST_POLL,
    S_WAIT    = ST_WAIT,
    S_FI      = ST_FI,
    S_ID      = ST_ID,
    S_DATA    = ST_DATA,
    S_REL     = ST_REL,
    S_PRESENT = ST_PRESENT
  } state_e;

  // Number of data bytes actually carried: none for remote frames, and DLC
  // values above 8 still mean 8 bytes on the wire.
  function automatic logic [3:0] payload_len(input logic rtr, input logic [3:0] dlc);
    if (rtr) begin
      payload_len = 4'd0;
    end else if (dlc > 4'd8) begin
      payload_len = 4'd8;
    end else begin
      payload_len = dlc;
    end
  endfunction

endpackage

// File: rtl/wb_byte_master.sv
// Single-byte Wishbone classic master with an ack timeout.
// Ports:
//   req/we/adr/wdat  - access request from the sequencer (held until done/tmo)
//   rdata            - read data captured on the ack edge
//   done             - one-clock pulse after a completed access
//   tmo              - one-clock pulse after an access aborted for lack of ack
//   wbm_*            - Wishbone master port (cyc/stb/adr/dat/we registered)
// done/tmo are used as a one-clock lockout so the still-asserted request of
// the sequencer cannot start a second access; this gives the idle gap.
module wb_byte_master #(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       we,
  input  logic [7:0] adr,
  input  logic [7:0] wdat,
  output logic [7:0] rdata,
  output logic       done,
  output logic       tmo,
  output logic [7:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  output logic       wbm_we_o,
  output logic       wbm_cyc_o,
  output logic       wbm_stb_o,
  input  logic       wbm_ack_i
);

  localparam int            CW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(ACK_TIMEOUT - 1);

  logic          active_r;
  logic [CW-1:0] cnt_r;
  logic [7:0]    adr_r;
  logic [7:0]    dat_r;
  logic          we_r;
  logic [7:0]    rdata_r;
  logic          done_r;
  logic          tmo_r;

  // Bus cycle control, ack-timeout counter and read-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      adr_r    <= 8'd0;
      dat_r    <= 8'd0;
      we_r     <= 1'b0;
      rdata_r  <= 8'd0;
      done_r   <= 1'b0;
      tmo_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      tmo_r  <= 1'b0;
      if (active_r) begin
        if (wbm_ack_i) begin
          active_r <= 1'b0;
          rdata_r  <= wbm_dat_i;
          done_r   <= 1'b1;
        end else if (cnt_r == TMO_LAST) begin
          active_r <= 1'b0;
          tmo_r    <= 1'b1;
        end else begin
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end else if (req && !done_r && !tmo_r) begin
        active_r <= 1'b1;
        cnt_r    <= {CW{1'b0}};
        adr_r    <= adr;
        dat_r    <= wdat;
        we_r     <= we;
      end
    end
  end

  assign wbm_cyc_o = active_r;
  assign wbm_stb_o = active_r;
  assign wbm_adr_o = adr_r;
  assign wbm_dat_o = dat_r;
  assign wbm_we_o  = we_r;
  assign rdata     = rdata_r;
  assign done      = done_r;
  assign tmo       = tmo_r;

endmodule

// File: rtl/can_rx_drain_master.sv
// Autonomous reader of the PeliCAN receive buffer: polls status, reads frame
// info, identifier and data, releases the buffer and then presents the frame
// on a valid/ready stream.
// Ports:
//   enable          - gates the start of a new poll only
//   wbm_*           - 8-bit Wishbone classic master to the controller
//   frm_valid/ready - frame stream handshake; frm_* held while valid && !ready
//   frm_ide/rtr/dlc/id/data - decoded frame (data byte 0 in [63:56])
//   bus_err         - one-clock pulse when an access times out
//   busy            - high outside IDLE and WAIT
module can_rx_drain_master
  import can_regs_pkg::*;
#(
  parameter int POLL_INTERVAL = 16,
  parameter int ACK_TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [7:0]  wbm_adr_o,
  output logic [7:0]  wbm_dat_o,
  input  logic [7:0]  wbm_dat_i,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  output logic        frm_valid,
  input  logic        frm_ready,
  output logic        frm_ide,
  output logic        frm_rtr,
  output logic [3:0]  frm_dlc,
  output logic [28:0] frm_id,
  output logic [63:0] frm_data,
  output logic        bus_err,
  output logic        busy
);

  localparam int           WW        = $clog2(POLL_INTERVAL + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(POLL_INTERVAL - 1);

  state_e        state_r;
  state_e        next_state_s;
  logic          req_s;
  logic          we_s;
  logic [7:0]    adr_s;
  logic [7:0]    wdat_s;
  logic [7:0]    rdata_s;
  logic          done_s;
  logic          tmo_s;
  logic [3:0]    id_last_s;
  logic [7:0]    data_base_s;

  logic [3:0]    idx_r;
  logic [WW-1:0] wait_cnt_r;
  logic [3:0]    nbytes_r;
  logic          ide_r;
  logic          rtr_r;
  logic [3:0]    dlc_r;
  logic [28:0]   id_r;
  logic [63:0]   data_r;
  logic          valid_r;
  logic          busy_r;

  wb_byte_master #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_bus (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_s),
    .we        (we_s),
    .adr       (adr_s),
    .wdat      (wdat_s),
    .rdata     (rdata_s),
    .done      (done_s),
    .tmo       (tmo_s),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_we_o  (wbm_we_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_ack_i (wbm_ack_i)
  );

  assign id_last_s   = ide_r ? 4'd3 : 4'd1;
  assign data_base_s = ide_r ? ADR_RX_DATA_EXT : ADR_RX_DATA_STD;

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and bus request generation
  always_comb begin
    next_state_s = state_r;
    req_s        = 1'b0;
    we_s         = 1'b0;
    adr_s        = 8'd0;
    wdat_s       = 8'd0;
    case (state_r)
      S_IDLE: begin
        if (enable) next_state_s = S_POLL;
        else        next_state_s = S_IDLE;
      end
      S_POLL: begin
        req_s = 1'b1;
        adr_s = ADR_SR;
        if (tmo_s)       next_state_s = S_WAIT;
        else if (done_s) next_state_s = rdata_s[SR_RBS] ? S_FI : S_WAIT;
        else             next_state_s = S_POLL;
      end
      S_WAIT: begin
        if (wait_cnt_r == WAIT_LAST) next_state_s = S_IDLE;
        else                         next_state_s = S_WAIT;
      end
      S_FI: begin
        req_s = 1'b1;
        adr_s = ADR_RX_FI;
        if (tmo_s)       next_state_s = S_WAIT;
        else if (done_s) next_state_s = S_ID;
        else             next_state_s = S_FI;
      end
      S_ID: begin
        req_s = 1'b1;
        adr_s = ADR_RX_ID + {4'd0, idx_r};
        if (tmo_s)                              next_state_s = S_WAIT;
        else if (done_s && idx_r == id_last_s)  next_state_s = (nbytes_r == 4'd0) ? S_REL : S_DATA;
        else                                    next_state_s = S_ID;
      end
      S_DATA: begin
        req_s = 1'b1;
        adr_s = data_base_s + {4'd0, idx_r};
        if (tmo_s)                                    next_state_s = S_WAIT;
        else if (done_s && idx_r == nbytes_r - 4'd1)  next_state_s = S_REL;
        else                                          next_state_s = S_DATA;
      end
      S_REL: begin
        req_s  = 1'b1;
        we_s   = 1'b1;
        adr_s  = ADR_CMD;
        wdat_s = CMD_RRB;
        if (tmo_s)       next_state_s = S_WAIT;
        else if (done_s) next_state_s = S_PRESENT;
        else             next_state_s = S_REL;
      end
      S_PRESENT: begin
        if (valid_r && frm_ready) next_state_s = S_IDLE;
        else                      next_state_s = S_PRESENT;
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // Frame assembly, byte/wait counters and registered stream/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r      <= 4'd0;
      wait_cnt_r <= {WW{1'b0}};
      nbytes_r   <= 4'd0;
      ide_r      <= 1'b0;
      rtr_r      <= 1'b0;
      dlc_r      <= 4'd0;
      id_r       <= 29'd0;
      data_r     <= 64'd0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      // byte index restarts on every state change, advances per completed access
      if (state_r != next_state_s) idx_r <= 4'd0;
      else if (done_s)             idx_r <= idx_r + 4'd1;

      if (state_r == S_WAIT) wait_cnt_r <= wait_cnt_r + {{(WW-1){1'b0}}, 1'b1};
      else                   wait_cnt_r <= {WW{1'b0}};

      // a new frame starts from a clean slate so unused bytes/ID bits read 0
      if (state_r == S_POLL && next_state_s == S_FI) begin
        ide_r    <= 1'b0;
        rtr_r    <= 1'b0;
        dlc_r    <= 4'd0;
        nbytes_r <= 4'd0;
        id_r     <= 29'd0;
        data_r   <= 64'd0;
      end

      if (state_r == S_FI && done_s) begin
        ide_r    <= rdata_s[7];
        rtr_r    <= rdata_s[6];
        dlc_r    <= rdata_s[3:0];
        nbytes_r <= payload_len(rdata_s[6], rdata_s[3:0]);
      end

      if (state_r == S_ID && done_s) begin
        if (ide_r) begin
          case (idx_r[1:0])
            2'd0:    id_r[28:21] <= rdata_s;
            2'd1:    id_r[20:13] <= rdata_s;
            2'd2:    id_r[12:5]  <= rdata_s;
            default: id_r[4:0]   <= rdata_s[7:3];
          endcase
        end else begin
          case (idx_r[1:0])
            2'd0:    id_r[10:3] <= rdata_s;
            default: id_r[2:0]  <= rdata_s[7:5];
          endcase
        end
      end

      if (state_r == S_DATA && done_s) begin
        data_r[6'd63 - {idx_r[2:0], 3'b000} -: 8] <= rdata_s;
      end

      valid_r <= (next_state_s == S_PRESENT);
      busy_r  <= (next_state_s != S_IDLE) && (next_state_s != S_WAIT);
    end
  end

  assign frm_valid = valid_r;
  assign frm_ide   = ide_r;
  assign frm_rtr   = rtr_r;
  assign frm_dlc   = dlc_r;
  assign frm_id    = id_r;
  assign frm_data  = data_r;
  assign bus_err   = tmo_s;
  assign busy      = busy_r;

endmodule

// File: tb/tb_can_rx_drain_master.sv
// Bench for can_rx_drain_master: a behavioural PeliCAN register-port slave
// with an RX FIFO of frames, and a frame-level expectation model.
module tb_can_rx_drain_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  wbm_adr_o;
  logic [7:0]  wbm_dat_o;
  logic [7:0]  wbm_dat_i;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_ack_i;
  logic        frm_valid;
  logic        frm_ready = 1'b0;
  logic        frm_ide;
  logic        frm_rtr;
  logic [3:0]  frm_dlc;
  logic [28:0] frm_id;
  logic [63:0] frm_data;
  logic        bus_err;
  logic        busy;

  always #5 clk = ~clk;

  can_rx_drain_master #(.POLL_INTERVAL(16), .ACK_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_ack_i(wbm_ack_i),
    .frm_valid(frm_valid), .frm_ready(frm_ready), .frm_ide(frm_ide),
    .frm_rtr(frm_rtr), .frm_dlc(frm_dlc), .frm_id(frm_id), .frm_data(frm_data),
    .bus_err(bus_err), .busy(busy)
  );

  typedef struct packed {
    logic        ide;
    logic        rtr;
    logic [3:0]  dlc;
    logic [28:0] id;
    logic [63:0] bytes;   // byte k at [63-8k -: 8]
  } frame_t;

  // ---------------- controller slave model ----------------
  frame_t      mem [0:15];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  frame_t      head;
  int unsigned ack_lat = 0;
  logic [7:0]  block_adr = 8'hFF;
  int unsigned wcnt = 0;
  logic [7:0]  log_adr [0:8191];
  logic        log_we  [0:8191];
  logic [7:0]  log_dat [0:8191];
  int unsigned log_n = 0;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [7:0] frame_byte(input frame_t f, input logic [7:0] adr);
    int k;
    logic [63:0] sh;
    k = int'(adr) - 17;
    if (f.ide) begin
      if (k == 0) return f.id[28:21];
      if (k == 1) return f.id[20:13];
      if (k == 2) return f.id[12:5];
      if (k == 3) return {f.id[4:0], f.rtr, 2'b01};
      k = k - 4;
    end else begin
      if (k == 0) return f.id[10:3];
      if (k == 1) return {f.id[2:0], f.rtr, 4'b1010};
      k = k - 2;
    end
    if (k > 7) return 8'h5A;
    sh = f.bytes << (8 * k);
    return sh[63:56];
  endfunction

  always_comb begin
    head      = mem[rd_ptr % 16];
    wbm_dat_i = 8'h00;
    if (wbm_adr_o == 8'd2)                            wbm_dat_i = {7'd0, (wr_ptr != rd_ptr)};
    else if (wbm_adr_o == 8'd16)                      wbm_dat_i = {head.ide, head.rtr, 2'b00, head.dlc};
    else if (wbm_adr_o == 8'd29)                      wbm_dat_i = 8'(wr_ptr - rd_ptr);
    else if (wbm_adr_o >= 8'd17 && wbm_adr_o <= 8'd28) wbm_dat_i = frame_byte(head, wbm_adr_o);
  end

  assign wbm_ack_i = wbm_cyc_o && wbm_stb_o && (wcnt >= ack_lat) && (wbm_adr_o != block_adr);

  always @(posedge clk) begin
    if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) wcnt <= wcnt + 1;
    else                                      wcnt <= 0;
    if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
      log_adr[log_n % 8192] <= wbm_adr_o;
      log_we[log_n % 8192]  <= wbm_we_o;
      log_dat[log_n % 8192] <= wbm_dat_o;
      log_n <= log_n + 1;
      if (wbm_we_o && wbm_adr_o == 8'd1 && wbm_dat_o[2] && rd_ptr != wr_ptr)
        rd_ptr <= rd_ptr + 1;
    end
  end

  // ---------------- frame-level expectation ----------------
  logic [98:0] obs;
  assign obs = {frm_ide, frm_rtr, frm_dlc, frm_id, frm_data};

  function automatic logic [98:0] model_frame(input frame_t f);
    int nb;
    logic [63:0] mask;
    logic [28:0] id;
    nb = f.rtr ? 0 : ((f.dlc > 4'd8) ? 8 : int'(f.dlc));
    mask = 64'd0;
    for (int k = 0; k < 8; k++) if (k < nb) mask[63 - 8 * k -: 8] = 8'hFF;
    id = f.ide ? f.id : {18'd0, f.id[10:0]};
    return {f.ide, f.rtr, f.dlc, id, f.bytes & mask};
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    f.ide   = 1'($urandom % 2);
    f.rtr   = ($urandom % 4) == 0;
    f.dlc   = 4'($urandom % 16);
    f.id    = 29'($urandom);
    f.bytes = {$urandom, $urandom};
    return f;
  endfunction

  task automatic push(input frame_t f);
    mem[wr_ptr % 16] = f;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = frm_valid;
    end
  endtask

  task automatic accept();
    frm_ready = 1'b1;
    @(negedge clk);
    frm_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_cyc_o, wbm_stb_o} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_bus: got %h want 0", {wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_cyc_o, wbm_stb_o});
    end
    vectors++;
    if ({frm_valid, obs, bus_err, busy} !== 102'd0) begin
      miscompares++;
      $display("FAIL reset_frame: got %h want 0", {frm_valid, obs, bus_err, busy});
    end
    rst_n = 1'b1;
    begin
      int act = 0;
      repeat (40) begin
        @(negedge clk);
        if (wbm_cyc_o || busy) act++;
      end
      vectors++;
      if (act !== 0) begin
        miscompares++;
        $display("FAIL disabled_idle: got %0d active cycles want 0", act);
      end
    end
  endtask

  task automatic test_ext_frame();
    frame_t f;
    bit ok;
    int j;
    f = '{ide: 1'b1, rtr: 1'b0, dlc: 4'd8, id: 29'h0123457, bytes: 64'hdeadbeefbadc0fff};
    enable = 1'b1;
    push(f);
    wait_valid(1000, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL ext_valid: timeout got 0 want 1"); end
    vectors++;
    if (obs !== model_frame(f)) begin
      miscompares++;
      $display("FAIL ext_fields: got %h want %h", obs, model_frame(f));
    end
    j = int'(log_n) - 1;
    while (j > 0 && log_adr[j % 8192] != 8'd16) j--;
    vectors++;
    if ({int'(log_n) - j, log_adr[(j - 1) % 8192]} !== {32'd14, 8'd2}) begin
      miscompares++;
      $display("FAIL ext_access_count: got %0d after status %0d want 14 after 2",
               int'(log_n) - j, log_adr[(j - 1) % 8192]);
    end
    accept();
    vectors++;
    if ({frm_valid, 8'(wr_ptr - rd_ptr)} !== 9'd0) begin
      miscompares++;
      $display("FAIL ext_after_accept: got valid=%b count=%0d want 0/0", frm_valid, wr_ptr - rd_ptr);
    end
  endtask

  task automatic test_std_frame();
    frame_t f;
    bit ok;
    int cnt;
    logic [7:0] a0, a1;
    int unsigned mark;
    f = '{ide: 1'b0, rtr: 1'b0, dlc: 4'd2, id: 29'h123, bytes: 64'hA55A_1122_3344_5566};
    mark = log_n;
    push(f);
    wait_valid(1000, ok);
    vectors++;
    if (obs !== model_frame(f) || !ok) begin
      miscompares++;
      $display("FAIL std_fields: got %h want %h", obs, model_frame(f));
    end
    cnt = 0; a0 = 8'd0; a1 = 8'd0;
    for (int unsigned i = mark; i < log_n; i++)
      if (!log_we[i % 8192] && log_adr[i % 8192] >= 8'd19 && log_adr[i % 8192] <= 8'd28) begin
        if (cnt == 0) a0 = log_adr[i % 8192];
        if (cnt == 1) a1 = log_adr[i % 8192];
        cnt++;
      end
    vectors++;
    if ({cnt, a0, a1} !== {32'd2, 8'd19, 8'd20}) begin
      miscompares++;
      $display("FAIL std_data_reads: got %0d reads (%0d,%0d) want 2 (19,20)", cnt, a0, a1);
    end
    accept();
  endtask

  task automatic test_rtr();
    frame_t f;
    bit ok;
    int hi, rel;
    int unsigned mark;
    f = '{ide: 1'b1, rtr: 1'b1, dlc: 4'd4, id: 29'h1ABCDEF, bytes: {$urandom, $urandom}};
    mark = log_n;
    push(f);
    wait_valid(1000, ok);
    vectors++;
    if (obs !== model_frame(f) || !ok) begin
      miscompares++;
      $display("FAIL rtr_fields: got %h want %h", obs, model_frame(f));
    end
    hi = 0; rel = 0;
    for (int unsigned i = mark; i < log_n; i++) begin
      if (!log_we[i % 8192] && log_adr[i % 8192] >= 8'd21 && log_adr[i % 8192] <= 8'd28) hi++;
      if (log_we[i % 8192] && log_adr[i % 8192] == 8'd1 && log_dat[i % 8192] == 8'h04) rel++;
    end
    vectors++;
    if ({hi, rel} !== {32'd0, 32'd1}) begin
      miscompares++;
      $display("FAIL rtr_bus: got data_reads=%0d releases=%0d want 0/1", hi, rel);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    frame_t q [3];
    bit ok;
    logic [98:0] snap;
    int moved, cycs;
    for (int i = 0; i < 3; i++) begin q[i] = rand_frame(); push(q[i]); end
    wait_valid(1500, ok);
    snap = obs;
    moved = 0; cycs = 0;
    repeat (500) begin
      @(negedge clk);
      if (obs !== snap || !frm_valid) moved++;
      if (wbm_cyc_o) cycs++;
    end
    vectors++;
    if ({moved, cycs} !== 64'd0) begin
      miscompares++;
      $display("FAIL b2b_hold: got %0d unstable, %0d bus cycles want 0/0", moved, cycs);
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) wait_valid(1500, ok);
      vectors++;
      if (obs !== model_frame(q[i]) || !ok) begin
        miscompares++;
        $display("FAIL b2b_frame%0d: got %h want %h", i, obs, model_frame(q[i]));
      end
      accept();
    end
    vectors++;
    if (wr_ptr - rd_ptr !== 0) begin
      miscompares++;
      $display("FAIL b2b_drained: got %0d frames left want 0", wr_ptr - rd_ptr);
    end
  endtask

  task automatic test_timeout();
    frame_t f;
    bit ok;
    int c18, errs, vals, gap;
    bit seen;
    f = rand_frame();
    f.rtr = 1'b0;
    block_adr = 8'd18;
    push(f);
    c18 = 0; errs = 0; vals = 0; seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (wbm_cyc_o && wbm_adr_o == 8'd18) c18++;
      if (frm_valid) vals++;
      if (bus_err) begin errs++; seen = 1'b1; end
    end
    vectors++;
    if ({seen, c18} !== {1'b1, 32'd64}) begin
      miscompares++;
      $display("FAIL tmo_len: got seen=%b cycles=%0d want 1/64", seen, c18);
    end
    gap = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      gap++;
      if (bus_err) errs++;
      if (frm_valid) vals++;
      if (wbm_cyc_o && wbm_adr_o == 8'd2) seen = 1'b1;
    end
    vectors++;
    if (!seen || gap < 16 || gap > 24 || errs != 1 || vals != 0) begin
      miscompares++;
      $display("FAIL tmo_recover: got repoll=%b gap=%0d errs=%0d valid=%0d want 1/16..24/1/0",
               seen, gap, errs, vals);
    end
    block_adr = 8'hFF;
    wait_valid(2000, ok);
    vectors++;
    if (obs !== model_frame(f) || !ok) begin
      miscompares++;
      $display("FAIL tmo_retry_frame: got %h want %h", obs, model_frame(f));
    end
    accept();
  endtask

  task automatic test_reset_mid();
    frame_t f;
    bit ok, hit;
    f = rand_frame();
    f.ide = 1'b1; f.rtr = 1'b0; f.dlc = 4'd8;
    push(f);
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      hit = wbm_cyc_o && wbm_adr_o == 8'd23;
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({hit, wbm_cyc_o, wbm_stb_o, frm_valid} !== 4'b1000) begin
      miscompares++;
      $display("FAIL mid_reset_drop: got hit/cyc/stb/valid=%b want 1000",
               {hit, wbm_cyc_o, wbm_stb_o, frm_valid});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_valid(1500, ok);
    vectors++;
    if (obs !== model_frame(f) || !ok) begin
      miscompares++;
      $display("FAIL mid_reset_reread: got %h want %h", obs, model_frame(f));
    end
    accept();
  endtask

  task automatic test_enable();
    frame_t f;
    bit ok, hit;
    int cycs;
    f = rand_frame();
    push(f);
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      hit = wbm_cyc_o && wbm_adr_o == 8'd16;
    end
    enable = 1'b0;
    wait_valid(1500, ok);
    vectors++;
    if (obs !== model_frame(f) || !ok || !hit) begin
      miscompares++;
      $display("FAIL enable_mid_frame: got %h want %h", obs, model_frame(f));
    end
    accept();
    cycs = 0;
    repeat (60) begin
      @(negedge clk);
      if (wbm_cyc_o) cycs++;
    end
    vectors++;
    if (cycs !== 0) begin
      miscompares++;
      $display("FAIL enable_off_poll: got %0d bus cycles want 0", cycs);
    end
    enable = 1'b1;
  endtask

  task automatic test_random();
    frame_t f;
    bit ok;
    for (int n = 0; n < 25; n++) begin
      ack_lat = $urandom % 4;
      f = rand_frame();
      push(f);
      wait_valid(3000, ok);
      repeat ($urandom % 6) @(negedge clk);
      vectors++;
      if (obs !== model_frame(f) || !ok) begin
        miscompares++;
        $display("FAIL random%0d: got %h want %h", n, obs, model_frame(f));
      end
      accept();
    end
    ack_lat = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_ext_frame();
    test_std_frame();
    test_rtr();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_enable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/can_rx_drain_master.md
Name: can_rx_drain_master

Overview:
- Autonomous host-side reader for the SJA1000-compatible controller; the hardware counterpart of the software send path that writes the TX buffer.
- Acts as an 8-bit Wishbone classic master on the controller's register port, running in PeliCAN (extended) mode.
- Polls receive-buffer status, reads frame info, ID and data from the RX window, then releases the receive buffer.
- Presents each frame on a valid/ready stream toward the system logic.

Parameters:
- POLL_INTERVAL, 16: idle clocks between status-register polls when the RX buffer is empty.
- ACK_TIMEOUT, 64: clocks to wait for wbm_ack_i before aborting an access.

Ports:
- clk  in  1  system clock, shared with the controller's Wishbone port.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  when 0, no new poll starts; an in-flight frame sequence completes.
- wbm_adr_o  out  8  register address.
- wbm_dat_o  out  8  write data.
- wbm_dat_i  in  8  read data.
- wbm_we_o  out  1  write strobe qualifier.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_ack_i  in  1  slave acknowledge.
- frm_valid  out  1  frame available.
- frm_ready  in  1  consumer accepts.
- frm_ide  out  1  1 = extended (29-bit) ID.
- frm_rtr  out  1  remote frame.
- frm_dlc  out  4  raw DLC.
- frm_id  out  29  identifier, right-aligned.
- frm_data  out  64  byte 0 in [63:56]; unused bytes are 0.
- bus_err  out  1  one-clock pulse on an ack timeout.
- busy  out  1  high in any state other than IDLE and WAIT.

Behaviour:
Reset:
- All outputs 0; state IDLE; poll counter 0.
- Asynchronous assertion aborts any bus cycle immediately: cyc and stb drop with reset.

Wishbone access rules:
- cyc and stb assert together, registered.
- adr, dat and we stay stable until the cycle in which ack is sampled high.
- cyc and stb deassert on the next edge; at least one idle clock separates accesses.
- The read data is captured on the ack edge.
- If ack is absent for ACK_TIMEOUT clocks: drop cyc/stb, pulse bus_err, discard the partial frame, go to WAIT.

State machine:
- IDLE: when enable=1, go to POLL.
- POLL: read addr 2 (status). If bit0 (RBS) is set, go to FI; else go to WAIT.
- WAIT: count POLL_INTERVAL clocks, then go to IDLE.
- FI: read addr 16.
  - ide = bit7, rtr = bit6, dlc = [3:0].
  - nbytes = 0 if rtr, else min(dlc, 8).
- ID: read 4 bytes (addr 17..20) if ide, else 2 bytes (17..18).
  - Extended: id[28:21]=b17, [20:13]=b18, [12:5]=b19, [4:0]=b20[7:3].
  - Standard: id[10:3]=b17, [2:0]=b18[7:5], id[28:11]=0.
- DATA: read nbytes bytes starting at addr 21 (extended) or 19 (standard).
  - Byte k goes to frm_data[63-8k -: 8].
  - frm_data is cleared to 0 on entry to FI.
  - If nbytes = 0, skip to REL.
- REL: write 0x04 (release receive buffer) to addr 1.
- PRESENT: frm_valid=1; all frm_* fields are held stable while valid && !ready.
  - On valid && ready: drop valid next clock, go to IDLE.
  - A re-poll therefore starts immediately, with no WAIT.

Boundary conditions:
- Release happens before presentation, so the controller FIFO is freed even under backpressure.
- No new poll starts while PRESENT is waiting.
- dlc 9..15: reports raw dlc and reads 8 data bytes.
- enable dropping mid-sequence has no effect until IDLE.
- A late ack arriving after a timeout is ignored (cyc=0).

Latency: an extended 8-byte frame costs 15 accesses (status, FI, 4 ID, 8 data, release). With zero-wait ack, each access is 3 clocks including the idle gap.

Decomposition:
- Shared package/include `can_regs`:
  - PeliCAN register addresses (CMD=1, SR=2, RX_FI=16, RX_ID=17, RX_DATA_EXT=21, RX_DATA_STD=19).
  - Command bit RRB=0x04 and status bit RBS=0.
  - State encoding localparams.
- One natural sub-module: `wb_byte_master`. It performs a single read or write with a req/done/timeout handshake and owns the ack timeout counter. The sequencer FSM sits above it.

Test Plan:
- Controller's Wishbone port connected through the drainer; a peer DUT sends extended frame id 0x0123457, dlc 8, data 0xdeadbeefbadc0fff → one frm_valid with ide=1, rtr=0, dlc=8, id=0x0123457, data=0xdeadbeefbadc0fff; controller RX frame count (addr 29) returns 0 afterwards.
- Standard frame id 0x123, dlc 2, data 0xA55A → id=0x123, frm_data=0xA55A000000000000, ide=0; exactly 2 data reads (addr 19, 20) are observed.
- Remote frame, extended id 0x1ABCDEF, dlc 4 → rtr=1, dlc=4, data=0; no reads of addr ≥21; release is written.
- Three frames back-to-back with frm_ready held 0 for 500 clocks → first frame held stable; no poll until accept; then all three are delivered in order with no loss.
- Slave model never acks addr 18 → bus_err pulses once after 64 clocks; no frm_valid; polling resumes after the WAIT interval.
- rst_n asserted during the DATA state → cyc/stb/frm_valid drop asynchronously; after release the frame is re-read intact from the still-unreleased buffer.
